// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - ROB head retirement, register write-back and mispredict flush sequencer
module commit_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int ROB_INDEX_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     head_valid,
    input  logic [4:0]               head_rd,
    input  logic [31:0]              head_value,
    input  logic [ROB_INDEX_BIT-1:0] head_rob_id,
    input  logic [31:0]              head_pc,
    input  logic                     head_mispredict,
    input  logic [31:0]              head_target_pc,
    output logic                     head_pop,
    output logic [4:0]               rf_set_value_id,
    output logic [31:0]              rf_set_value,
    output logic [ROB_INDEX_BIT-1:0] rf_set_value_rob_id,
    output logic                     clear,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     busy,
    output logic [31:0]              commit_count,
    output logic                     dbg_commit,
    output logic [31:0]              dbg_commit_addr
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WB_LAST = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // The first FLUSH cycle is counted by the WB_LAST transition itself.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  flush_cnt;
    logic [31:0] target_pc;
    logic [31:0] count_q;

    assign head_pop     = rst_in && rdy_in && (state == ST_IDLE) && head_valid;
    assign busy         = (state != ST_IDLE);
    assign commit_count = count_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state               <= ST_IDLE;
            flush_cnt           <= 4'd0;
            target_pc           <= 32'd0;
            count_q             <= 32'd0;
            rf_set_value_id     <= 5'd0;
            rf_set_value        <= 32'd0;
            rf_set_value_rob_id <= '0;
            clear               <= 1'b0;
            redirect_valid      <= 1'b0;
            redirect_pc         <= 32'd0;
            dbg_commit          <= 1'b0;
            dbg_commit_addr     <= 32'd0;
        end else if (rdy_in) begin
            rf_set_value_id <= 5'd0;
            dbg_commit      <= 1'b0;
            clear           <= 1'b0;
            redirect_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (head_pop) begin
                        rf_set_value_id     <= head_rd;
                        rf_set_value        <= head_value;
                        rf_set_value_rob_id <= head_rob_id;
                        dbg_commit          <= 1'b1;
                        dbg_commit_addr     <= head_pc;
                        count_q             <= count_q + 32'd1;
                        // Hold off the clear one cycle so the register file keeps this write.
                        if (head_mispredict) begin
                            state     <= ST_WB_LAST;
                            target_pc <= head_target_pc;
                        end
                    end
                end
                ST_WB_LAST: begin
                    state          <= ST_FLUSH;
                    clear          <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target_pc;
                    flush_cnt      <= FLUSH_LOAD;
                end
                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// tb/tb_commit_ctrl.sv - scoreboard bench for commit_ctrl against a transaction-level model
module tb_commit_ctrl;

    localparam int F  = 3;
    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, head_valid, head_mispredict;
    logic [4:0]    head_rd;
    logic [31:0]   head_value, head_pc, head_target_pc;
    logic [RB-1:0] head_rob_id;
    logic          head_pop, clear, redirect_valid, busy, dbg_commit;
    logic [4:0]    rf_set_value_id;
    logic [31:0]   rf_set_value, redirect_pc, commit_count, dbg_commit_addr;
    logic [RB-1:0] rf_set_value_rob_id;

    commit_ctrl #(.FLUSH_CYCLES(F), .ROB_INDEX_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .head_valid(head_valid), .head_rd(head_rd), .head_value(head_value),
        .head_rob_id(head_rob_id), .head_pc(head_pc),
        .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
        .head_pop(head_pop), .rf_set_value_id(rf_set_value_id),
        .rf_set_value(rf_set_value), .rf_set_value_rob_id(rf_set_value_rob_id),
        .clear(clear), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .commit_count(commit_count),
        .dbg_commit(dbg_commit), .dbg_commit_addr(dbg_commit_addr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            edge_n;
        logic [4:0]    rd;
        logic [31:0]   val;
        logic [RB-1:0] rob;
        logic [31:0]   pc;
    } commit_t;
    typedef struct {
        int          edge_n;
        logic [31:0] tgt;
    } redir_t;

    commit_t cq[$];
    redir_t  rq[$];

    // Model: count of ready edges, blocked-edge budget after a mispredict, retired count.
    int          m_edges = 0;
    int          m_block = 0;
    logic [31:0] m_count = 32'd0;
    bit          m_fresh = 1'b0;
    bit          mon_on  = 1'b0;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive at posedge+1, check head_pop before the edge, then apply the model at the edge.
    task automatic step(input bit rst, input bit rdy, input bit vld, input logic [4:0] rd,
                        input logic [31:0] val, input logic [RB-1:0] rob, input logic [31:0] pc,
                        input bit mis, input logic [31:0] tgt);
        bit exp_pop;
        rst_in = rst; rdy_in = rdy; head_valid = vld; head_rd = rd; head_value = val;
        head_rob_id = rob; head_pc = pc; head_mispredict = mis; head_target_pc = tgt;
        #3;
        exp_pop = rst && rdy && vld && (m_block == 0);
        chk("head_pop", {31'd0, head_pop}, {31'd0, exp_pop});
        @(posedge clk_in);
        if (!rst) begin
            m_block = 0; m_count = 32'd0; m_fresh = 1'b1;
            cq.delete(); rq.delete();
        end else if (rdy) begin
            m_edges++;
            m_fresh = 1'b1;
            if (exp_pop) begin
                m_count = m_count + 32'd1;
                cq.push_back('{m_edges, rd, val, rob, pc});
                if (mis) begin
                    m_block = 1 + F;
                    rq.push_back('{m_edges + 1, tgt});
                end
            end else if (m_block > 0) begin
                m_block--;
            end
        end else begin
            m_fresh = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, rdy, 1'b0, 5'd0, 32'd0, '0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] val, input bit mis,
                          input logic [31:0] tgt);
        step(1'b1, 1'b1, 1'b1, rd, val, RB'(rd), 32'h400 + {27'd0, rd}, mis, tgt);
    endtask

    always @(negedge clk_in) begin
        if (mon_on) begin
            bit exp_c, exp_r;
            chk("commit_count", commit_count, m_count);
            chk("busy", {31'd0, busy}, {31'd0, (m_block > 0)});
            if (m_fresh) begin
                exp_c = (cq.size() > 0) && (cq[0].edge_n == m_edges);
                exp_r = (rq.size() > 0) && (rq[0].edge_n == m_edges);
                chk("dbg_commit", {31'd0, dbg_commit}, {31'd0, exp_c});
                chk("clear", {31'd0, clear}, {31'd0, exp_r});
                chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_r});
                if (exp_c) begin
                    chk("rf_set_value_id", {27'd0, rf_set_value_id}, {27'd0, cq[0].rd});
                    chk("rf_set_value", rf_set_value, cq[0].val);
                    chk("rf_set_value_rob_id", {28'd0, rf_set_value_rob_id}, {28'd0, cq[0].rob});
                    chk("dbg_commit_addr", dbg_commit_addr, cq[0].pc);
                    void'(cq.pop_front());
                end else begin
                    chk("rf_set_value_id_idle", {27'd0, rf_set_value_id}, 32'd0);
                end
                if (exp_r) begin
                    chk("redirect_pc", redirect_pc, rq[0].tgt);
                    void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b0; head_valid = 1'b0; head_rd = 5'd0; head_value = 32'd0;
        head_rob_id = '0; head_pc = 32'd0; head_mispredict = 1'b0; head_target_pc = 32'd0;
        @(posedge clk_in); #1;
        step(1'b0, 1'b0, 1'b1, 5'd1, 32'd1, '0, 32'd0, 1'b0, 32'd0);
        mon_on = 1'b1;
        step(1'b0, 1'b1, 1'b1, 5'd1, 32'd1, '0, 32'd0, 1'b1, 32'd0);

        // Streaming, including an rd=0 commit
        commit(5'd1, 32'h10, 1'b0, 32'd0);
        commit(5'd2, 32'h11, 1'b0, 32'd0);
        commit(5'd0, 32'h12, 1'b0, 32'd0);
        commit(5'd3, 32'h13, 1'b0, 32'd0);
        idle(1'b1);

        // Mispredict with head_valid held high through WB_LAST/FLUSH
        commit(5'd5, 32'hAB, 1'b1, 32'h1000);
        repeat (F + 2) commit(5'd6, 32'hCD, 1'b0, 32'd0);

        // Stall after a commit, head still valid
        commit(5'd7, 32'h77, 1'b0, 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 5'd8, 32'h88, '0, 32'd0, 1'b0, 32'd0);
        idle(1'b1);

        // Reset in the first FLUSH cycle
        commit(5'd9, 32'h99, 1'b1, 32'h2000);
        idle(1'b1);
        step(1'b0, 1'b1, 1'b1, 5'd1, 32'd1, '0, 32'd0, 1'b0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Counter wrap
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFE;
        commit(5'd10, 32'hA0, 1'b0, 32'd0);
        commit(5'd11, 32'hA1, 1'b0, 32'd0);
        commit(5'd12, 32'hA2, 1'b0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) >= 2), ($urandom_range(99) < 80), ($urandom_range(99) < 70),
                 5'($urandom), $urandom, RB'($urandom), $urandom,
                 ($urandom_range(99) < 15), $urandom);
        end
        repeat (F + 4) idle(1'b1);
        mon_on = 1'b0;
        chk("commit_queue_empty", cq.size(), 32'd0);
        chk("redirect_queue_empty", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
